// File: rtl/beat_timing_sequencer.sv
// Beat timing sequencer: three-phase T ring and W beat one-hot
// for the hardwired controller, with debounced start and stepping.
module beat_timing_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DB_LIMIT    = 4,
    parameter int DB_CNT_W    = 8
) (
    input  logic       CLK,
    input  logic       CLR,
    input  logic       QD,
    input  logic       DP,
    input  logic       SHORT,
    input  logic       LONG,
    input  logic       STOP,
    output logic [2:0] T,
    output logic [2:0] W,
    output logic       RUN
);

    typedef enum logic {
        HALT    = 1'b0,
        RUNNING = 1'b1
    } state_t;

    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_LIMIT - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [2:0]             t_d;
    logic [2:0]             w_d;
    logic [2:0]             w_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   db_level;
    logic [DB_CNT_W-1:0]    db_cnt;
    logic                   start_evt;

    assign synced = sync_q[SYNC_STAGES-1];
    assign RUN    = (state_q == RUNNING);

    // Bring the asynchronous button into the CLK domain.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], QD};
        end
    end

    // Debounce: level follows synced value only after DB_LIMIT
    // consecutive differing cycles; a 0->1 change emits start_evt.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            db_level  <= 1'b0;
            db_cnt    <= '0;
            start_evt <= 1'b0;
        end else begin
            start_evt <= 1'b0;
            if (synced == db_level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_level  <= synced;
                db_cnt    <= '0;
                start_evt <= synced;
            end else begin
                db_cnt <= db_cnt + DB_CNT_W'(1);
            end
        end
    end

    // Beat chosen at the T3 boundary; SHORT wins over LONG in W1.
    always_comb begin
        w_next = 3'b001;
        unique case (1'b1)
            W[0]:    w_next = SHORT ? 3'b001 : 3'b010;
            W[1]:    w_next = LONG ? 3'b100 : 3'b001;
            W[2]:    w_next = 3'b001;
            default: w_next = 3'b001;
        endcase
    end

    // Next state: phase rotation, beat advance and halting decisions.
    always_comb begin
        state_d = state_q;
        t_d     = T;
        w_d     = W;
        unique case (state_q)
            HALT: begin
                if (start_evt) begin
                    state_d = RUNNING;
                    t_d     = 3'b001;
                end
            end
            RUNNING: begin
                unique case (1'b1)
                    T[2]: begin
                        w_d = w_next;
                        if (STOP || DP) begin
                            t_d     = 3'b000;
                            state_d = HALT;
                        end else begin
                            t_d = 3'b001;
                        end
                    end
                    T[1]:    t_d = 3'b100;
                    T[0]:    t_d = 3'b010;
                    default: t_d = 3'b001;
                endcase
            end
            default: begin
                state_d = HALT;
                t_d     = 3'b000;
            end
        endcase
    end

    // Registered timing outputs.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            state_q <= HALT;
            T       <= 3'b000;
            W       <= 3'b001;
        end else begin
            state_q <= state_d;
            T       <= t_d;
            W       <= w_d;
        end
    end

endmodule

// File: tb/tb_beat_timing_sequencer.sv
// Directed bench for beat_timing_sequencer: start latency, beat
// sequencing, SHORT/LONG/STOP/DP handling, debounce and reset.
module tb_beat_timing_sequencer;

    logic       CLK;
    logic       CLR;
    logic       QD;
    logic       DP;
    logic       SHORT;
    logic       LONG;
    logic       STOP;
    logic [2:0] T;
    logic [2:0] W;
    logic       RUN;

    int total;
    int bad;

    beat_timing_sequencer dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .QD    (QD),
        .DP    (DP),
        .SHORT (SHORT),
        .LONG  (LONG),
        .STOP  (STOP),
        .T     (T),
        .W     (W),
        .RUN   (RUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic halted(input string tag, input int ew);
        chk({tag, "_T"}, T, 0);
        chk({tag, "_W"}, W, ew);
        chk({tag, "_RUN"}, RUN, 0);
    endtask

    // At a negedge expecting T1: checks the three phases of one beat,
    // returning at the T3 negedge so controls can be set for the edge.
    task automatic beat_chk(input string tag, input int ew);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge CLK);
            chk({tag, "_T"}, T, 1 << i);
            chk({tag, "_W"}, W, ew);
            chk({tag, "_RUN"}, RUN, 1);
        end
    endtask

    task automatic go(input string tag, input int ew);
        @(negedge CLK);
        beat_chk(tag, ew);
    endtask

    task automatic press_wait(output int n);
        n  = 0;
        QD = 1'b1;
        while (T != 3'b001 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("start_seen", T, 1);
        QD = 1'b0;
    endtask

    initial begin
        int n;
        int cnt;
        int ew[3];
        int en[3];
        total = 0;
        bad   = 0;
        CLR   = 1'b0;
        QD    = 1'b0;
        DP    = 1'b0;
        SHORT = 1'b0;
        LONG  = 1'b0;
        STOP  = 1'b0;

        repeat (3) @(negedge CLK);
        halted("rst", 1);
        CLR = 1'b1;
        repeat (50) @(negedge CLK);
        halted("idle", 1);

        // Free run from a clean press.
        QD = 1'b1;
        n  = 0;
        while (T != 3'b001 && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("lat_le8", int'(n <= 8), 1);
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge CLK);
            chk("free_T", T, 1 << (i % 3));
            chk("free_W", W, ((i / 3) % 2) != 0 ? 2 : 1);
            chk("free_RUN", RUN, 1);
        end
        QD = 1'b0;

        // SHORT holds W1; then LONG gives W1, W2, W3, W1.
        SHORT = 1'b1;
        go("short", 1);
        go("short", 1);
        go("short", 1);
        go("short", 1);
        SHORT = 1'b0;
        LONG  = 1'b1;
        go("long", 2);
        go("long", 4);
        go("long", 1);
        go("long", 2);
        LONG = 1'b0;
        go("long_drop", 1);

        // STOP in W2 with LONG granted holds W3.
        LONG = 1'b1;
        go("pre_stop", 2);
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        LONG = 1'b0;
        halted("stop", 4);
        repeat (30) @(negedge CLK);
        halted("stop_hold", 4);

        // Resume continues with the held W3, then step-halt into W1.
        press_wait(n);
        beat_chk("resume", 4);
        DP = 1'b1;
        @(negedge CLK);
        halted("resume_halt", 1);

        // Single stepping: one beat per press.
        ew = '{1, 2, 1};
        en = '{2, 1, 2};
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(negedge CLK);
            chk("step_idle_RUN", RUN, 0);
            press_wait(n);
            beat_chk("step", ew[k]);
            @(negedge CLK);
            halted("step_halt", en[k]);
        end

        // Bouncing button yields a single start.
        repeat (10) @(negedge CLK);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            QD = ((i / 2) % 2) == 0;
            @(negedge CLK);
            if (T == 3'b001) cnt++;
        end
        chk("bounce_quiet", cnt, 0);
        QD = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (T == 3'b001) cnt++;
        end
        QD = 1'b0;
        chk("bounce_once", cnt, 1);
        halted("bounce_halt", 1);

        // Press while running leaves the sequence untouched.
        DP = 1'b0;
        repeat (10) @(negedge CLK);
        press_wait(n);
        beat_chk("run_a", 1);
        go("run_a", 2);
        go("run_a", 1);
        QD = 1'b1;
        go("run_b", 2);
        go("run_b", 1);
        go("run_b", 2);
        go("run_b", 1);
        QD   = 1'b0;
        STOP = 1'b1;
        @(negedge CLK);
        STOP = 1'b0;
        halted("run_stop", 2);
        repeat (20) @(negedge CLK);
        halted("no_queue", 2);

        // Asynchronous reset mid-beat at T2/W2.
        press_wait(n);
        chk("pre_rst_W", W, 2);
        @(negedge CLK);
        chk("pre_rst_T", T, 2);
        CLR = 1'b0;
        #1;
        halted("async_rst", 1);
        @(negedge CLK);
        CLR = 1'b1;
        repeat (5) @(negedge CLK);
        halted("post_rst", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/beat_timing_sequencer.md
Name: beat_timing_sequencer

Overview:
- Generates machine timing for the hardwired controller: the three-phase clock ring T1/T2/T3 and the beat one-hot W[3:1].
- Honours the controller's SHORT, LONG and STOP requests.
- Starts and resumes on the debounced console start button QD.
- Supports single-beat stepping (DP).
- Sits between the board clock and the controller; the controller's registered state updates on the falling edge of T3 produced here.

Parameters:
- SYNC_STAGES, 2: synchroniser flops on QD (min 2).
- DB_LIMIT, 4: consecutive CLK cycles synced QD must be stable before the debounced level changes (1..255).
- DB_CNT_W, 8: debounce counter width; must hold DB_LIMIT.

Ports:
- CLK input 1: board clock; all state updates on its rising edge.
- CLR input 1: reset, asynchronous, active-low.
- QD input 1: console start button, asynchronous, bouncy, active-high.
- DP input 1: single-step mode; 1 halts after every beat.
- SHORT input 1: from controller; in W1, next beat is W1 again.
- LONG input 1: from controller; in W2, next beat is W3.
- STOP input 1: from controller; halt after the current beat.
- T output 3: phase one-hot {T3,T2,T1}; 000 when halted.
- W output 3: beat one-hot {W3,W2,W1}.
- RUN output 1: 1 while the phase ring is cycling.

Behaviour:
- All outputs are registered.
- CLR low, at any time (including mid-beat or mid-debounce), immediately forces:
  - T=000, W=001, RUN=0.
  - Synchroniser flops, debounced level and debounce counter cleared to 0.
- Debounce:
  - QD passes through SYNC_STAGES flops.
  - Counter resets whenever the synced value equals the debounced level; otherwise it increments.
  - When the counter reaches DB_LIMIT, the debounced level takes the synced value and the counter clears.
  - start_evt is a one-CLK registered pulse on a debounced 0->1 transition.
- States: HALT (RUN=0) and RUNNING (RUN=1); the phase is part of RUNNING.
- HALT -> RUNNING on the edge where start_evt=1: RUN<=1, T<=001. W keeps its held value.
- In RUNNING, T rotates every CLK: 001 -> 010 -> 100 -> 001.
- Beat boundary = the CLK edge leaving T3 (T=100). At that edge SHORT, LONG, STOP and DP are sampled. Next W:
  - W=001: SHORT ? 001 : 010.
  - W=010: LONG ? 100 : 001.
  - W=100: always 001.
  - SHORT is ignored outside W1; LONG is ignored outside W2; both high in W1 -> SHORT governs.
- Halt at the beat boundary if STOP=1 or DP=1: W takes its new value, T<=000, RUN<=0.
  - Otherwise T<=001, with the next beat starting immediately (no gap cycle).
- Controls sampled only at the beat boundary; changes of SHORT/LONG/STOP/DP during T1/T2 have no effect.
- start_evt while RUNNING is ignored and not queued.
- start_evt coinciding with the halting edge is ignored; a fresh button press is required.
- Latency:
  - Beat = exactly 3 CLK.
  - QD clean rise -> T1 in at most SYNC_STAGES+DB_LIMIT+2 CLK.
  - STOP sampled -> T=000 on that same edge.
- Resume after halt continues with the held W (e.g. W3 if LONG had been granted), never with a forced W1.

Test Plan:
- Reset: CLR=0 during RUNNING at T2/W2 -> same cycle T=000, W=001, RUN=0. CLR=1 and no QD for 50 CLK -> outputs unchanged.
- Free run: QD clean high 20 CLK, SHORT=LONG=STOP=DP=0 -> T cycles 001,010,100. W: 001 for 3 CLK, 010 for 3 CLK, repeating. T1 within 8 CLK of QD rise (defaults).
- SHORT/LONG:
  - SHORT=1 constant -> W stays 001 for 4 beats.
  - SHORT=0, LONG=1 -> W sequence 001,010,100,001 (3 CLK each).
  - LONG=1 during W1 only -> W1 then W2, no W3.
- STOP: LONG=1, STOP raised during W2 T3 -> next edge T=000, RUN=0, W=100. Held 30 CLK. Second QD press -> T=001 with W=100, then W1.
- Single step: DP=1, three QD presses -> exactly three beats of 3 CLK each, W 001,010,001. RUN low between presses.
- Bounce: QD toggles every 2 CLK for 12 CLK, then stable high -> exactly one start_evt. QD press while RUNNING -> no change to T/W sequence.
